// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the mac_seq dot-product sequencer.
// Internal arithmetic is carried in MAX_W bits, so ACC_W must stay below MAX_W.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ACC_W = 24;
  localparam int MAX_W     = 64;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             ovf;
  } add_res_t;

  // Sign-extend a value whose sign bit sits at position msb to MAX_W bits.
  function automatic logic [MAX_W-1:0] sext_prod(input logic [MAX_W-1:0] prod,
                                                 input logic [5:0]       msb);
    logic [MAX_W-1:0] upper;
    upper = {MAX_W{1'b1}} << msb;
    return prod[msb] ? (prod | upper) : (prod & ~upper);
  endfunction

  // Add two values of width msb+1 (already sign-extended) and flag signed overflow.
  function automatic add_res_t add_ovf(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input logic [5:0]       msb);
    add_res_t r;
    r.sum = a + b;
    r.ovf = (a[msb] == b[msb]) && (r.sum[msb] != a[msb]);
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_mm.sv
// mm: combinational sign-magnitude multiplier producing a two's-complement product.
module mm #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_mag_i,
  input  logic          a_sign_i,
  input  logic [DW-1:0] w_mag_i,
  input  logic          w_sign_i,
  output logic [2*DW:0] prod_o
);

  logic [2*DW-1:0] mag;
  logic [2*DW:0]   pos;

  assign mag = {{DW{1'b0}}, a_mag_i} * {{DW{1'b0}}, w_mag_i};
  assign pos = {1'b0, mag};
  // A zero magnitude negates to zero, so negative zero needs no special case.
  assign prod_o = (a_sign_i ^ w_sign_i) ? (~pos + 1'b1) : pos;

endmodule

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer sharing one mm multiplier across a job of operand pairs.
// Build option MAC_SEQ_SATURATE_EN: saturate the accumulator instead of wrapping.
module mac_seq
  import mac_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LEN_W = DEF_LEN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    a_mag_i,
  input  logic             a_sign_i,
  input  logic [DW-1:0]    w_mag_i,
  input  logic             w_sign_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_acc_o,
  output logic             out_ovf_o
);

  localparam int         PW       = 2*DW + 1;
  localparam logic [5:0] ACC_MSB  = 6'(ACC_W - 1);
  localparam logic [5:0] PROD_MSB = 6'(PW - 1);

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    mm_prod;
  logic [MAX_W-1:0] acc_ext;
  logic [MAX_W-1:0] prod_ext;
  add_res_t         add_r;
  logic             unused_sum_bits;

  mm #(.DW(DW)) u_mm (
    .a_mag_i  (a_mag_i),
    .a_sign_i (a_sign_i),
    .w_mag_i  (w_mag_i),
    .w_sign_i (w_sign_i),
    .prod_o   (mm_prod)
  );

  assign acc_ext         = sext_prod({{(MAX_W-ACC_W){1'b0}}, acc_q}, ACC_MSB);
  assign prod_ext        = sext_prod({{(MAX_W-PW){1'b0}}, prod_q}, PROD_MSB);
  assign add_r           = add_ovf(acc_ext, prod_ext, ACC_MSB);
  assign unused_sum_bits = ^add_r.sum[MAX_W-1:ACC_W];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    prod_d      = prod_q;
    prod_v_d    = 1'b0;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    busy_o      = (state_q != IDLE);
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    // The registered product lands one cycle after its handshake, so the last
    // one is absorbed during DRAIN.
    if (prod_v_q) begin
`ifdef MAC_SEQ_SATURATE_EN
      if (add_r.ovf) begin
        acc_d = acc_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = add_r.sum[ACC_W-1:0];
      end
`else
      acc_d = add_r.sum[ACC_W-1:0];
`endif
      ovf_d = ovf_q | add_r.ovf;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          if (len_i != '0) begin
            len_d   = len_i;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          prod_d   = mm_prod;
          prod_v_d = 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == len_q - 1'b1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      count_q  <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_acc_o = acc_q;
  assign out_ovf_o = ovf_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed self-checking bench for mac_seq; a second 17-bit accumulator instance covers overflow.
module tb_mac_seq;

  localparam int DW      = 8;
  localparam int LEN_W   = 8;
  localparam int ACC_W   = 24;
  localparam int ACC_W_N = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [DW-1:0]    a_mag;
  logic             a_sign;
  logic [DW-1:0]    w_mag;
  logic             w_sign;
  logic             out_ready;

  logic                      busy, in_ready, out_valid, out_ovf;
  logic signed [ACC_W-1:0]   out_acc;
  logic                      busy_n, in_ready_n, out_valid_n, out_ovf_n;
  logic signed [ACC_W_N-1:0] out_acc_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_seq #(.DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .len_i       (len),
    .busy_o      (busy),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_mag_i     (a_mag),
    .a_sign_i    (a_sign),
    .w_mag_i     (w_mag),
    .w_sign_i    (w_sign),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_acc_o   (out_acc),
    .out_ovf_o   (out_ovf)
  );

  mac_seq #(.DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_W_N)) dut_n (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .len_i       (len),
    .busy_o      (busy_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_n),
    .a_mag_i     (a_mag),
    .a_sign_i    (a_sign),
    .w_mag_i     (w_mag),
    .w_sign_i    (w_sign),
    .out_valid_o (out_valid_n),
    .out_ready_i (out_ready),
    .out_acc_o   (out_acc_n),
    .out_ovf_o   (out_ovf_n)
  );

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    stepClk();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic sendPair(input logic [DW-1:0] am, input logic as_, input logic [DW-1:0] wm,
                          input logic ws);
    logic ready_now;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    a_mag    = am;
    a_sign   = as_;
    w_mag    = wm;
    w_sign   = ws;
    for (int i = 0; i < 20; i++) begin
      ready_now = in_ready;
      stepClk();
      if (ready_now) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) checkOutput("handshake_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a_mag     = '0;
    a_sign    = 1'b0;
    w_mag     = '0;
    w_sign    = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    stepClk();
    stepClk();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_acc", out_acc, 0);
    checkOutput("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    stepClk();

    // Job 1: three back-to-back pairs, 12 - 30 - 14 = -32.
    applyStimulus(8'd3);
    checkOutput("j1_busy", busy, 1);
    checkOutput("j1_in_ready", in_ready, 1);
    sendPair(8'd3, 1'b0, 8'd4, 1'b0);
    sendPair(8'd5, 1'b1, 8'd6, 1'b0);
    sendPair(8'd7, 1'b0, 8'd2, 1'b1);
    checkOutput("j1_drain_valid", out_valid, 0);
    checkOutput("j1_drain_ready", in_ready, 0);
    stepClk();
    checkOutput("j1_valid", out_valid, 1);
    checkOutput("j1_acc", out_acc, -32);
    checkOutput("j1_ovf", out_ovf, 0);
    out_ready = 1'b1;
    stepClk();
    out_ready = 1'b0;
    checkOutput("j1_idle_busy", busy, 0);
    checkOutput("j1_idle_valid", out_valid, 0);

    // Zero-length job goes straight to DONE with a cleared sum.
    applyStimulus(8'd0);
    checkOutput("z_valid", out_valid, 1);
    checkOutput("z_acc", out_acc, 0);
    checkOutput("z_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput("z_hold_valid", out_valid, 1);
      checkOutput("z_hold_acc", out_acc, 0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd3;
    stepClk();
    out_ready = 1'b0;
    start     = 1'b0;
    len       = '0;
    checkOutput("z_idle_busy", busy, 0);
    checkOutput("z_idle_valid", out_valid, 0);
    stepClk();
    checkOutput("z_start_ignored", busy, 0);

    // Job 2: extreme products with input gaps, 65025 - 65025 = 0.
    applyStimulus(8'd2);
    sendPair(8'd255, 1'b1, 8'd255, 1'b1);
    for (int i = 0; i < 2; i++) begin
      stepClk();
      checkOutput("j2_gap_busy", busy, 1);
      checkOutput("j2_gap_ready", in_ready, 1);
    end
    sendPair(8'd255, 1'b0, 8'd255, 1'b1);
    checkOutput("j2_busy", busy, 1);
    stepClk();
    checkOutput("j2_valid", out_valid, 1);
    checkOutput("j2_acc", out_acc, 0);
    checkOutput("j2_ovf", out_ovf, 0);
    out_ready = 1'b1;
    stepClk();
    out_ready = 1'b0;

    // Job 3: 2 x 65025 overflows the 17-bit instance but not the 24-bit one.
    applyStimulus(8'd2);
    sendPair(8'd255, 1'b0, 8'd255, 1'b0);
    sendPair(8'd255, 1'b0, 8'd255, 1'b0);
    stepClk();
    checkOutput("j3_valid", out_valid, 1);
    checkOutput("j3_acc_wide", out_acc, 130050);
    checkOutput("j3_ovf_wide", out_ovf, 0);
    checkOutput("j3_valid_n", out_valid_n, 1);
`ifdef MAC_SEQ_SATURATE_EN
    checkOutput("j3_acc_n", out_acc_n, 65535);
`else
    checkOutput("j3_acc_n", out_acc_n, -1022);
`endif
    checkOutput("j3_ovf_n", out_ovf_n, 1);
    out_ready = 1'b1;
    stepClk();
    out_ready = 1'b0;

    // Job 4: reset mid-job aborts everything.
    applyStimulus(8'd4);
    sendPair(8'd5, 1'b0, 8'd5, 1'b0);
    sendPair(8'd5, 1'b0, 8'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_in_ready", in_ready, 0);
    checkOutput("mr_out_valid", out_valid, 0);
    checkOutput("mr_out_acc", out_acc, 0);
    checkOutput("mr_out_ovf", out_ovf, 0);
    stepClk();
    rst_n = 1'b1;
    stepClk();
    checkOutput("mr_post_busy", busy, 0);
    applyStimulus(8'd1);
    sendPair(8'd1, 1'b1, 8'd1, 1'b0);
    stepClk();
    checkOutput("j4_valid", out_valid, 1);
    checkOutput("j4_acc", out_acc, -1);
    out_ready = 1'b1;
    stepClk();
    out_ready = 1'b0;

    // Job 5: negative zero times 200 contributes nothing.
    applyStimulus(8'd1);
    sendPair(8'd0, 1'b1, 8'd200, 1'b0);
    stepClk();
    checkOutput("j5_valid", out_valid, 1);
    checkOutput("j5_acc", out_acc, 0);
    checkOutput("j5_ovf", out_ovf, 0);
    out_ready = 1'b1;
    stepClk();
    out_ready = 1'b0;
    checkOutput("j5_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Dot-product sequencer that time-shares one sign-magnitude multiplier (existing `mm`, DW-bit magnitudes, (2*DW+1)-bit two's-complement product).
- Accepts a job length, streams operand pairs over a valid/ready handshake, and registers each product.
- Accumulates the products into a signed accumulator.
- Presents the final sum on a valid/ready output port.
- Sits between the operand fetch logic and the result writeback in the MAC array.

Parameters:
- DW, 8, operand magnitude width (passed to `mm`).
- LEN_W, 8, width of the job-length field; maximum job is 2^LEN_W-1 pairs.
- ACC_W, 24, accumulator width; must be ≥ 2*DW+1.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job start pulse; sampled only in IDLE.
- len  input  LEN_W  number of operand pairs; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer accepts a pair.
- a_mag  input  DW  A magnitude.
- a_sign  input  1  A sign.
- w_mag  input  DW  W magnitude.
- w_sign  input  1  W sign.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_acc  output  ACC_W  signed dot-product result.
- out_ovf  output  1  sticky overflow flag for the job.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - acc, count, prod_q and prod_v are cleared.
  - All outputs read 0 (busy, in_ready, out_valid, out_acc, out_ovf).
  - Asserting reset mid-job aborts the job immediately; no partial result is ever presented.
- FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with len≠0: latch len, clear acc, ovf and count, go to RUN.
  - start=1 with len=0: clear acc and ovf, go to DONE (result 0).
- RUN:
  - in_ready=1 (combinationally, from state only).
  - Handshake (in_valid & in_ready): the `mm` product is registered into prod_q, prod_v=1 next cycle, count increments.
  - The handshake with count==len-1 moves the FSM to DRAIN.
  - A cycle without handshake sets prod_v=0 next cycle.
- Accumulation:
  - Every cycle prod_v=1: acc <= acc + sign-extend(prod_q) to ACC_W.
  - Accumulation happens in RUN and DRAIN.
- DRAIN:
  - in_ready=0.
  - One cycle, during which the last product is added.
  - Next state is DONE.
- DONE:
  - out_valid=1; out_acc=acc and out_ovf are held stable until accepted.
  - out_valid & out_ready moves the FSM to IDLE; acc is not cleared until the next start.
- Latency:
  - out_valid rises 2 cycles after the final input handshake.
  - Throughput is one pair per cycle.
- start outside IDLE is ignored, including start in the same cycle as the output handshake.
- Negative zero (magnitude 0 with either sign) contributes 0.
- Extreme product: ±(2^DW-1)^2, i.e. ±65025 for DW=8.
- Overflow, default build:
  - acc wraps modulo 2^ACC_W.
  - out_ovf is set sticky when the true sum leaves the signed ACC_W range, detected from the sign bits of the operands and the result.
- in_valid may drop at any time; no pair may be lost or duplicated.

Optional Feature:
- Macro: MAC_SEQ_SATURATE_EN.
- Defined: each add saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow. out_ovf is set sticky, and later adds continue from the clamped value.
- Undefined: wrap-around accumulation as above; out_ovf still reports wrap.

Decomposition:
- Shared package mac_pkg holds:
  - mac_state_e enum (IDLE, RUN, DRAIN, DONE).
  - Default DW/ACC_W localparams.
  - Function sext_prod(prod) -> ACC_W.
  - Function add_ovf(a, b) returning the sum and an overflow bit.
- One sub-module instance: `mm`, the existing sign-magnitude multiplier. No other sub-modules.

Test Plan:
- len=3; pairs (+3,+4), (-5,+6), (+7,-2), all back-to-back → out_valid 2 cycles after the 3rd handshake, out_acc=-32, out_ovf=0.
- len=2; pairs (-255,-255), (+255,-255) with in_valid gaps of 2 idle cycles → out_acc=0. Each pair is accepted exactly once; busy stays 1 throughout.
- len=0, start → DONE the next cycle, out_acc=0. Hold out_ready=0 for 5 cycles → output stable; out_ready=1 → IDLE. A start in that same handshake cycle is ignored.
- ACC_W=17, len=2, pairs (+255,+255) twice:
  - Default build → out_acc wraps to 130050-131072 = -1022, out_ovf=1.
  - With MAC_SEQ_SATURATE_EN → out_acc=65535, out_ovf=1.
- len=4; after 2 handshakes assert rst_n=0 for 1 cycle → all outputs 0, FSM in IDLE. A new job len=1 (-1,+1) → out_acc=-1.
- Pair (0, sign -) × (200, +) in a len=1 job → out_acc=0 (negative zero).
